// File: rtl/reg_file_bypass_pkg.sv
// Shared types and default sizes for the bypassing register file.
package reg_file_pkg;
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} rfState_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/reg_file_bypass_if.sv
// Write/reserve/read bus of the register file; clk and rst_n stay outside.
interface reg_file_bypass_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W_DEF,
  parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF
);
  logic              clr_req;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_pend1;
  logic              rd_pend2;
  logic              ready;

  modport master (
    output clr_req, we, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, rd_pend1, rd_pend2, ready
  );

  modport slave (
    input  clr_req, we, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, rd_pend1, rd_pend2, ready
  );
endinterface

// File: rtl/reg_file_bypass_clear_seq.sv
// Clear sequencer: walks every entry after reset or a clear request, then idles.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clrReq,
  output logic              ready,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrAddr
);
  rfState_e          state, stateNxt;
  logic [ADDR_W-1:0] clrCnt, cntNxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrCnt <= '0;
    end else begin
      state  <= stateNxt;
      clrCnt <= cntNxt;
    end
  end

  // Counter saturates on the last entry so it never wraps back to 0 while idle.
  always_comb begin
    stateNxt = state;
    cntNxt   = clrCnt;
    case (state)
      CLEAR: begin
        if (&clrCnt) stateNxt = IDLE;
        else         cntNxt   = clrCnt + ADDR_W'(1);
      end
      IDLE: begin
        if (clrReq) begin
          stateNxt = CLEAR;
          cntNxt   = '0;
        end
      end
      default: begin
        stateNxt = CLEAR;
        cntNxt   = '0;
      end
    endcase
  end

  assign ready   = (state == IDLE);
  assign clrWe   = (state == CLEAR);
  assign clrAddr = clrCnt;
endmodule

// File: rtl/reg_file_bypass.sv
// Two-read/one-write register file with per-entry pending (scoreboard) bits.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_bypass
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                rst_n,
  reg_file_bypass_if.slave   bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NUM_RD = 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              ready, clrWe;
  logic [ADDR_W-1:0] clrAddr;
  logic              wrAct, wrEn;

  rf_clear_seq #(.ADDR_W(ADDR_W)) uClearSeq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clrReq  (bus.clr_req),
    .ready   (ready),
    .clrWe   (clrWe),
    .clrAddr (clrAddr)
  );

  // A clear request on the same edge drops the write.
  assign wrAct = ready && bus.we && !bus.clr_req;
  assign wrEn  = wrAct && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clrWe)     mem[clrAddr]     <= '0;
      else if (wrEn) mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Reserve is applied after the write clear so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (ready && bus.clr_req) begin
      pend <= '0;
    end else if (ready) begin
      if (bus.we)     pend[bus.wr_addr]  <= 1'b0;
      if (bus.rsv_en) pend[bus.rsv_addr] <= 1'b1;
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] rdAddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]             rdPend;

  assign rdAddr = {bus.rd_addr2, bus.rd_addr1};

  for (genvar g = 0; g < NUM_RD; g++) begin : gRd
    logic isZero, hit;
    assign isZero = (ZERO_REG != 0) && (rdAddr[g] == '0);
`ifdef REG_FILE_BYPASS_EN
    assign hit = wrAct && (rdAddr[g] == bus.wr_addr);
`else
    assign hit = 1'b0;
`endif
    assign rdData[g] = (!ready || isZero) ? '0
                     : hit                ? bus.wr_data
                     :                      mem[rdAddr[g]];
    assign rdPend[g] = ready && !isZero && !hit && pend[rdAddr[g]];
  end

  assign bus.rd_data1 = rdData[0];
  assign bus.rd_data2 = rdData[1];
  assign bus.rd_pend1 = rdPend[0];
  assign bus.rd_pend2 = rdPend[1];
  assign bus.ready    = ready;
endmodule

// File: tb/tb_reg_file_bypass.sv
// Randomized self-checking bench for reg_file_bypass against a behavioural model.
module tb_reg_file_bypass;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_file_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: clearing takes DEPTH edges; the array content is invisible meanwhile.
  logic [DW-1:0] mMem [DEPTH];
  bit            mPend [DEPTH];
  int            clearLeft = DEPTH;

  function automatic bit mReady();
    return clearLeft == 0;
  endfunction

  function automatic bit bypassHit(int a);
`ifdef REG_FILE_BYPASS_EN
    return mReady() && bus.we && !bus.clr_req && a == int'(bus.wr_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] expData(int a);
    if (!mReady() || a == 0) return '0;
    if (bypassHit(a)) return bus.wr_data;
    return mMem[a];
  endfunction

  function automatic bit expPend(int a);
    if (!mReady() || a == 0 || bypassHit(a)) return 1'b0;
    return mPend[a];
  endfunction

  function automatic void startClear();
    clearLeft = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      mMem[i]  = '0;
      mPend[i] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) startClear();
    else if (clearLeft > 0) clearLeft--;
    else if (bus.clr_req) startClear();
    else begin
      if (bus.we) begin
        if (bus.wr_addr != 0) mMem[bus.wr_addr] = bus.wr_data;
        mPend[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_en) mPend[bus.rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idleInputs();
    bus.clr_req = 0; bus.we = 0; bus.rsv_en = 0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rsv_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idleInputs();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    repeat (3) tick();
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.ready); end
    rst_n = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checks++;
      if (bus.ready !== (i == DEPTH)) begin
        errors++; $display("FAIL reset_count edge %0d ready got %b exp %b", i, bus.ready, i == DEPTH);
      end
    end
    for (int k = 0; k < 4; k++) begin
      bus.rd_addr1 = AW'($urandom_range(0, DEPTH - 1));
      #1; checks++;
      if (bus.rd_data1 !== '0 || bus.rd_pend1 !== 1'b0) begin
        errors++; $display("FAIL reset_zero addr %0d got %h/%b exp 0/0", bus.rd_addr1, bus.rd_data1, bus.rd_pend1);
      end
    end
  endtask

  task automatic test_write_read();
    bus.we = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.we = 0; bus.rd_addr1 = 5; #1; checks++;
    if (bus.rd_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_r5 got %h exp deadbeef", bus.rd_data1);
    end
    bus.we = 1; bus.wr_addr = 0; bus.wr_data = 32'h1234;
    tick();
    bus.we = 0; bus.rd_addr1 = 0; #1; checks++;
    if (bus.rd_data1 !== '0) begin
      errors++; $display("FAIL zero_reg got %h exp 0", bus.rd_data1);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    bus.rd_addr2 = 7; bus.we = 1; bus.wr_addr = 7; bus.wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = '0;
`endif
    checks++;
    if (bus.rd_data2 !== exp) begin
      errors++; $display("FAIL bypass_same got %h exp %h", bus.rd_data2, exp);
    end
    tick();
    bus.we = 0; #1; checks++;
    if (bus.rd_data2 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_after got %h exp a5a5a5a5", bus.rd_data2);
    end
  endtask

  task automatic test_pending();
    bit exp;
    bus.rsv_en = 1; bus.rsv_addr = 3;
    tick();
    bus.rsv_en = 0; bus.rd_addr1 = 3; #1; checks++;
    if (bus.rd_pend1 !== 1'b1) begin errors++; $display("FAIL pend_set got %b exp 1", bus.rd_pend1); end
    tick(); checks++;
    if (bus.rd_pend1 !== 1'b1) begin errors++; $display("FAIL pend_hold got %b exp 1", bus.rd_pend1); end
    bus.we = 1; bus.wr_addr = 3; bus.wr_data = 32'h55; #1;
`ifdef REG_FILE_BYPASS_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    checks++;
    if (bus.rd_pend1 !== exp) begin errors++; $display("FAIL pend_wr_same got %b exp %b", bus.rd_pend1, exp); end
    tick();
    bus.we = 0; #1; checks++;
    if (bus.rd_pend1 !== 1'b0) begin errors++; $display("FAIL pend_clr got %b exp 0", bus.rd_pend1); end
    bus.we = 1; bus.wr_addr = 3; bus.rsv_en = 1; bus.rsv_addr = 3;
    tick();
    bus.we = 0; bus.rsv_en = 0; #1; checks++;
    if (bus.rd_pend1 !== 1'b1) begin errors++; $display("FAIL pend_rsv_wins got %b exp 1", bus.rd_pend1); end
  endtask

  task automatic test_clear();
    bus.clr_req = 1; bus.we = 1; bus.wr_addr = 9; bus.wr_data = $urandom;
    tick();
    idleInputs();
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL clear_busy edge %0d ready got %b exp 0", i, bus.ready); end
      tick();
    end
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL clear_done ready got %b exp 1", bus.ready); end
    bus.rd_addr1 = 9; #1; checks++;
    if (bus.rd_data1 !== '0) begin errors++; $display("FAIL clear_r9 got %h exp 0", bus.rd_data1); end
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr1 = AW'(a); bus.rd_addr2 = AW'(DEPTH - 1 - a); #1; checks++;
      if (bus.rd_pend1 !== 1'b0 || bus.rd_pend2 !== 1'b0 || bus.rd_data1 !== '0) begin
        errors++; $display("FAIL clear_all addr %0d got %h/%b/%b exp 0/0/0", a, bus.rd_data1, bus.rd_pend1, bus.rd_pend2);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    repeat (10) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checks++;
      if (bus.ready !== (i == DEPTH)) begin
        errors++; $display("FAIL midclr_reset edge %0d ready got %b exp %b", i, bus.ready, i == DEPTH);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.clr_req  = ($urandom_range(0, 63) == 0);
      bus.we       = $urandom_range(0, 1);
      bus.wr_addr  = AW'($urandom_range(0, 7));
      bus.wr_data  = $urandom;
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = AW'($urandom_range(0, 7));
      bus.rd_addr1 = AW'($urandom_range(0, 7));
      bus.rd_addr2 = AW'($urandom_range(0, 7));
      #1; checks++;
      if (bus.ready !== mReady() ||
          bus.rd_data1 !== expData(bus.rd_addr1) || bus.rd_data2 !== expData(bus.rd_addr2) ||
          bus.rd_pend1 !== expPend(bus.rd_addr1) || bus.rd_pend2 !== expPend(bus.rd_addr2)) begin
        errors++;
        $display("FAIL rand cyc %0d got rdy%b %h/%b %h/%b exp rdy%b %h/%b %h/%b", n,
                 bus.ready, bus.rd_data1, bus.rd_pend1, bus.rd_data2, bus.rd_pend2,
                 mReady(), expData(bus.rd_addr1), expPend(bus.rd_addr1),
                 expData(bus.rd_addr2), expPend(bus.rd_addr2));
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_pending();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
